// File: rtl/eight_b_usr.sv
// eight_b_usr: 8-bit universal shift register (hold, shift right, shift left, parallel load).
// The register drives out directly, so out has no combinational path from any input.
module eight_b_usr (
    output logic [7:0] out,
    input  logic [7:0] pload,
    input  logic       lftin,
    input  logic       rghtin,
    input  logic [1:0] select,
    input  logic       clk,
    input  logic       rst
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    mode_t      mode;
    logic [7:0] shreg;
    logic [7:0] shreg_next;

    assign mode = mode_t'(select);

    // All four codes are legal, so the default arm only exists to keep the case complete.
    always_comb begin
        shreg_next = shreg;
        unique case (mode)
            MODE_HOLD: shreg_next = shreg;
            MODE_SHR:  shreg_next = {rghtin, shreg[7:1]};
            MODE_SHL:  shreg_next = {shreg[6:0], lftin};
            MODE_LOAD: shreg_next = pload;
            default:   shreg_next = shreg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            shreg <= 8'h00;
        else
            shreg <= shreg_next;
    end

    assign out = shreg;

endmodule

// File: tb/tb_eight_b_usr.sv
// Directed self-checking bench for eight_b_usr; expected values are hand-computed constants.
// Inputs change 1ns after each rising edge and out is sampled at that same point.
module tb_eight_b_usr;

    logic [7:0] out;
    logic [7:0] pload;
    logic       lftin;
    logic       rghtin;
    logic [1:0] select;
    logic       clk;
    logic       rst;

    int errors = 0;
    int checks = 0;

    eight_b_usr dut (
        .out    (out),
        .pload  (pload),
        .lftin  (lftin),
        .rghtin (rghtin),
        .select (select),
        .clk    (clk),
        .rst    (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; select = 2'b11; pload = 8'hFF; lftin = 1'b1; rghtin = 1'b1;
        tick();
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_clear: got %h expected %h", out, 8'h00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_release_load: got %h expected %h", out, 8'hFF);
        end
    endtask

    task automatic test_load();
        logic [7:0] vals [4] = '{8'h00, 8'h41, 8'h8E, 8'hA5};
        select = 2'b11; lftin = 1'b0; rghtin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pload = vals[i];
            tick();
            checks++;
            if (out !== vals[i]) begin
                errors++;
                $display("[TB] FAIL load_%0d: got %h expected %h", i, out, vals[i]);
            end
        end
    endtask

    task automatic test_shift_right();
        logic       bits [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp  [5] = '{8'hD2, 8'hE9, 8'h74, 8'h3A, 8'h1D};
        select = 2'b01; pload = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            rghtin = bits[i];
            lftin  = ~bits[i];
            tick();
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("[TB] FAIL shift_right_%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        select = 2'b00;
        for (int i = 0; i < 3; i++) begin
            lftin  = i[0];
            rghtin = ~i[0];
            pload  = (i == 1) ? 8'hFF : 8'h5A;
            tick();
            checks++;
            if (out !== 8'h1D) begin
                errors++;
                $display("[TB] FAIL hold_%0d: got %h expected %h", i, out, 8'h1D);
            end
        end
    endtask

    task automatic test_shift_left();
        logic       bits [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp  [5] = '{8'h3B, 8'h77, 8'hEF, 8'hDE, 8'hBC};
        select = 2'b10; pload = 8'h00;
        for (int i = 0; i < 5; i++) begin
            lftin  = bits[i];
            rghtin = ~bits[i];
            tick();
            checks++;
            if (out !== exp[i]) begin
                errors++;
                $display("[TB] FAIL shift_left_%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        select = 2'b10; lftin = 1'b1;
        tick();
        checks++;
        if (out !== 8'h79) begin
            errors++;
            $display("[TB] FAIL pre_reset_shift: got %h expected %h", out, 8'h79);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid_shift: got %h expected %h", out, 8'h00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out !== 8'h01) begin
            errors++;
            $display("[TB] FAIL post_reset_shift: got %h expected %h", out, 8'h01);
        end
    endtask

    // Eight shifts in one direction leave exactly the last eight serial bits in out.
    task automatic test_full_shift();
        logic [7:0] rpat = 8'h4D;
        logic [7:0] lpat = 8'h96;
        select = 2'b01; lftin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rghtin = rpat[i];
            tick();
        end
        checks++;
        if (out !== 8'h4D) begin
            errors++;
            $display("[TB] FAIL full_shift_right: got %h expected %h", out, 8'h4D);
        end
        select = 2'b10; rghtin = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            lftin = lpat[i];
            tick();
        end
        checks++;
        if (out !== 8'h96) begin
            errors++;
            $display("[TB] FAIL full_shift_left: got %h expected %h", out, 8'h96);
        end
    endtask

    // Mode changes on every edge with no idle cycles between them.
    task automatic test_back_to_back();
        select = 2'b11; pload = 8'h81; lftin = 1'b0; rghtin = 1'b0;
        tick();
        select = 2'b01; rghtin = 1'b0;
        tick();
        checks++;
        if (out !== 8'h40) begin
            errors++;
            $display("[TB] FAIL b2b_right: got %h expected %h", out, 8'h40);
        end
        select = 2'b10; lftin = 1'b1;
        tick();
        checks++;
        if (out !== 8'h81) begin
            errors++;
            $display("[TB] FAIL b2b_left: got %h expected %h", out, 8'h81);
        end
        select = 2'b01; rghtin = 1'b1;
        tick();
        checks++;
        if (out !== 8'hC0) begin
            errors++;
            $display("[TB] FAIL b2b_right_in1: got %h expected %h", out, 8'hC0);
        end
        select = 2'b11; pload = 8'h3C;
        tick();
        checks++;
        if (out !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL b2b_load: got %h expected %h", out, 8'h3C);
        end
    endtask

    initial begin
        rst = 1'b0; select = 2'b00; pload = 8'h00; lftin = 1'b0; rghtin = 1'b0;
        #1;
        test_reset();
        test_load();
        test_shift_right();
        test_hold();
        test_shift_left();
        test_reset_mid_shift();
        test_full_shift();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
